// File: rtl/multi_bounded_loop_ctr_if.sv
// Control/status bundle for multi_bounded_loop_ctr: run handshake and per-channel step controls in, counters and status out.
// Purely combinational wiring; no latency, and no backpressure beyond the start handshake.
interface multi_bounded_loop_ctr_if #(
    parameter int WIDTH  = 32,
    parameter int NCH    = 4,
    parameter int ITER_W = 16
);
    logic                   start;
    logic [WIDTH-1:0]       bound_in;
    logic                   loop_en;
    logic [NCH-1:0]         ch_en;
    logic [NCH-1:0]         inc;
    logic [NCH*WIDTH-1:0]   c_out;
    logic [WIDTH-1:0]       bound_out;
    logic [1:0]             state_out;
    logic [ITER_W-1:0]      iter_out;
    logic                   done;
    logic                   err;

    modport master (
        output start, bound_in, loop_en, ch_en, inc,
        input  c_out, bound_out, state_out, iter_out, done, err
    );

    modport slave (
        input  start, bound_in, loop_en, ch_en, inc,
        output c_out, bound_out, state_out, iter_out, done, err
    );
endinterface

// File: rtl/multi_bounded_loop_ctr.sv
// NCH bounded counters in [0, bound_q] under one IDLE/LOOP/DONE controller; all outputs are registers or decodes of them.
// One-cycle step latency; start is taken only in IDLE/DONE and ignored while a run is in LOOP.
module multi_bounded_loop_ctr #(
    parameter int          WIDTH         = 32,
    parameter int          NCH           = 4,
    parameter int unsigned DEFAULT_BOUND = 4,
    parameter int          WRAP_MODE     = 0,
    parameter int          ITER_W        = 16,
    parameter int unsigned MAX_ITER      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    multi_bounded_loop_ctr_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ITER_W:0] LP_MAX_ITER = (ITER_W+1)'(MAX_ITER);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_c [NCH];
    logic [WIDTH-1:0]  w_c_nxt [NCH];
    logic [WIDTH-1:0]  r_bound;
    logic [ITER_W-1:0] r_iter;
    logic [NCH-1:0]    w_over;
    logic              w_accept;
    logic              w_step;
    logic              w_iter_cap;

    assign w_accept   = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_step     = (r_state == ST_LOOP) && bus.loop_en;
    // Compare one bit wider so a saturated iter never aliases onto MAX_ITER.
    assign w_iter_cap = (MAX_ITER != 0) && (({1'b0, r_iter} + 1'b1) == LP_MAX_ITER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_LOOP;
            ST_LOOP: if (!bus.loop_en || w_iter_cap) w_state_nxt = ST_DONE;
            ST_DONE: if (bus.start) w_state_nxt = ST_LOOP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.state_out = r_state;
        bus.done      = (r_state == ST_DONE);
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_c_nxt[i] = r_c[i];
            if (bus.ch_en[i]) begin
                if (bus.inc[i]) begin
                    if (r_c[i] != r_bound) w_c_nxt[i] = r_c[i] + 1'b1;
                end else if (WRAP_MODE == 2) begin
                    if (r_c[i] != '0) w_c_nxt[i] = r_c[i] - 1'b1;
                end else if (r_c[i] == r_bound) begin
                    w_c_nxt[i] = (WRAP_MODE == 0) ? WIDTH'(1) : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) r_c[i] <= '0;
            r_bound <= WIDTH'(DEFAULT_BOUND);
            r_iter  <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NCH; i++) r_c[i] <= '0;
            r_bound <= (bus.bound_in == '0) ? WIDTH'(1) : bus.bound_in;
            r_iter  <= '0;
        end else if (w_step) begin
            for (int i = 0; i < NCH; i++) r_c[i] <= w_c_nxt[i];
            if (!(&r_iter)) r_iter <= r_iter + 1'b1;
        end
    end

    always_comb begin
        bus.c_out = '0;
        w_over    = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.c_out[i*WIDTH +: WIDTH] = r_c[i];
            w_over[i]                   = (r_c[i] > r_bound);
        end
    end

    assign bus.err       = |w_over;
    assign bus.bound_out = r_bound;
    assign bus.iter_out  = r_iter;

    for (genvar g = 0; g < NCH; g++) begin : g_inv
        a_c_le_bound: assert property (@(posedge clk) disable iff (!rst) r_c[g] <= r_bound);
    end

    a_bound_nz:    assert property (@(posedge clk) disable iff (!rst) r_bound != '0);
    a_no_err:      assert property (@(posedge clk) disable iff (!rst) !bus.err);
    a_state_legal: assert property (@(posedge clk) disable iff (!rst) r_state != 2'd3);
    a_idle_zero:   assert property (@(posedge clk) disable iff (!rst) (r_state == ST_IDLE) |-> (bus.c_out == '0));
    a_done_hold:   assert property (@(posedge clk) disable iff (!rst)
                       (r_state == ST_DONE && !bus.start) |=> ($stable(bus.c_out) && $stable(r_bound)));

endmodule

// File: tb/tb_multi_bounded_loop_ctr.sv
// Random and directed stimulus on four parameter variants against an arithmetic reference model.
module tb_multi_bounded_loop_ctr;
    localparam int W    = 8;
    localparam int N    = 4;
    localparam int IW   = 16;
    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start    = 1'b0;
    logic [W-1:0] bound_in = '0;
    logic         loop_en  = 1'b0;
    logic [N-1:0] ch_en    = '0;
    logic [N-1:0] inc      = '0;

    logic [NDUT-1:0][N*W-1:0] o_c;
    logic [NDUT-1:0][W-1:0]   o_bound;
    logic [NDUT-1:0][1:0]     o_state;
    logic [NDUT-1:0][IW-1:0]  o_iter;
    logic [NDUT-1:0]          o_done;
    logic [NDUT-1:0]          o_err;

    multi_bounded_loop_ctr_if #(.WIDTH(W), .NCH(N), .ITER_W(IW)) bus [NDUT] ();

    // Variants 0..2 exercise each wrap mode; variant 3 is wrap mode 0 with a 3-iteration cap.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign bus[g].start    = start;
        assign bus[g].bound_in = bound_in;
        assign bus[g].loop_en  = loop_en;
        assign bus[g].ch_en    = ch_en;
        assign bus[g].inc      = inc;
        assign o_c[g]     = bus[g].c_out;
        assign o_bound[g] = bus[g].bound_out;
        assign o_state[g] = bus[g].state_out;
        assign o_iter[g]  = bus[g].iter_out;
        assign o_done[g]  = bus[g].done;
        assign o_err[g]   = bus[g].err;

        multi_bounded_loop_ctr #(
            .WIDTH(W), .NCH(N), .DEFAULT_BOUND(4),
            .WRAP_MODE((g == 3) ? 0 : g), .ITER_W(IW),
            .MAX_ITER((g == 3) ? 3 : 0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    int unsigned m_c     [NDUT][N];
    int unsigned m_bound [NDUT];
    int unsigned m_state [NDUT];
    int unsigned m_iter  [NDUT];

    function automatic int wrap_of(int k);
        return (k == 3) ? 0 : k;
    endfunction

    function automatic int unsigned cap_of(int k);
        return (k == 3) ? 3 : 0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NDUT; k++) begin
            for (int ch = 0; ch < N; ch++) m_c[k][ch] = 0;
            m_bound[k] = 4;
            m_state[k] = 0;
            m_iter[k]  = 0;
        end
    endtask

    // State codes: 0 idle, 1 loop, 2 done.
    task automatic m_step();
        for (int k = 0; k < NDUT; k++) begin
            if (m_state[k] != 1) begin
                if (start) begin
                    m_bound[k] = (bound_in == 0) ? 1 : int'(bound_in);
                    for (int ch = 0; ch < N; ch++) m_c[k][ch] = 0;
                    m_iter[k]  = 0;
                    m_state[k] = 1;
                end
            end else if (!loop_en) begin
                m_state[k] = 2;
            end else begin
                for (int ch = 0; ch < N; ch++) begin
                    if (ch_en[ch]) begin
                        if (inc[ch]) begin
                            if (m_c[k][ch] < m_bound[k]) m_c[k][ch] = m_c[k][ch] + 1;
                        end else if (wrap_of(k) == 2) begin
                            if (m_c[k][ch] > 0) m_c[k][ch] = m_c[k][ch] - 1;
                        end else if (m_c[k][ch] == m_bound[k]) begin
                            m_c[k][ch] = (wrap_of(k) == 0) ? 1 : 0;
                        end
                    end
                end
                if (m_iter[k] < 65535) m_iter[k] = m_iter[k] + 1;
                if (cap_of(k) != 0 && m_iter[k] == cap_of(k)) m_state[k] = 2;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            for (int ch = 0; ch < N; ch++)
                chk($sformatf("d%0d_c%0d", k, ch), o_c[k][ch*W +: W], m_c[k][ch]);
            chk($sformatf("d%0d_bound", k), o_bound[k], m_bound[k]);
            chk($sformatf("d%0d_state", k), o_state[k], m_state[k]);
            chk($sformatf("d%0d_iter", k), o_iter[k], m_iter[k]);
            chk($sformatf("d%0d_done", k), o_done[k], (m_state[k] == 2) ? 1 : 0);
            chk($sformatf("d%0d_err", k), o_err[k], 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        m_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_bound", o_bound[0], 4);
        chk("rst_state", o_state[0], 0);
        rst = 1'b1;

        // Zero bound is promoted to 1.
        start = 1'b1; bound_in = '0; loop_en = 1'b0;
        tick();
        chk("b0_bound", o_bound[0], 1);
        chk("b0_state", o_state[0], 1);
        start = 1'b0;
        tick();
        chk("done_flag", o_done[0], 1);

        start = 1'b1; bound_in = W'(4);
        tick();
        start = 1'b0; loop_en = 1'b1; ch_en = 4'b0001; inc = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("sat_seq%0d", i), o_c[0][W-1:0], (i < 4) ? i + 1 : 4);
        end
        chk("c1_still", o_c[0][2*W-1:W], 0);
        chk("iter6", o_iter[0], 6);

        // Non-increment step with c0 at bound.
        inc = 4'b0000;
        tick();
        chk("wrap0", o_c[0][W-1:0], 1);
        chk("wrap1", o_c[1][W-1:0], 0);
        chk("wrap2", o_c[2][W-1:0], 3);
        repeat (4) tick();
        chk("wrap2_floor", o_c[2][W-1:0], 0);

        // Iteration cap on variant 3.
        loop_en = 1'b0; ch_en = '0;
        tick();
        start = 1'b1; bound_in = W'(5); loop_en = 1'b1;
        tick();
        start = 1'b0; ch_en = 4'b0001; inc = 4'b1111;
        tick();
        tick();
        chk("cap_mid_state", o_state[3], 1);
        tick();
        chk("cap_state", o_state[3], 2);
        chk("cap_iter", o_iter[3], 3);
        chk("cap_done", o_done[3], 1);
        chk("pre_arst_c0", o_c[0][W-1:0], 3);

        start = 1'b1; bound_in = W'(7); ch_en = '0;
        tick();
        start = 1'b0;
        chk("restart_bound", o_bound[3], 7);
        chk("restart_state", o_state[3], 1);
        chk("restart_c0", o_c[3][W-1:0], 0);
        chk("loop_start_ignored", o_bound[0], 5);

        // Asynchronous reset between edges.
        #2 rst = 1'b0;
        #1;
        chk("arst_c", o_c[0], 0);
        chk("arst_state", o_state[0], 0);
        chk("arst_bound", o_bound[0], 4);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        check_all();

        for (int cyc = 0; cyc < 2000; cyc++) begin
            start = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       bound_in = '0;
                1:       bound_in = '1;
                2:       bound_in = W'($urandom_range(1, 6));
                default: bound_in = W'($urandom);
            endcase
            loop_en = ($urandom_range(0, 15) != 0);
            ch_en   = N'($urandom);
            inc     = N'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_bounded_loop_ctr.md
Name: multi_bounded_loop_ctr

Overview:
- Parametrised, multi-channel successor of the single-channel bounded-counter loop model.
- NCH independent counters share one IDLE/LOOP/DONE controller.
- Each counter is kept within [0, bound]. The bound is loaded at run start instead of being fixed at 4.
- Adds a start handshake, selectable wrap mode, an iteration cap, and an invariant-violation flag. Used as a formal benchmark target and as a reusable bounded-counter engine.

Parameters:
- WIDTH, 32, counter and bound width.
- NCH, 4, number of counter channels.
- DEFAULT_BOUND, 4, bound_q value after reset.
- WRAP_MODE, 0, action on a non-increment step at bound: 0 = load 1, 1 = load 0, 2 = decrement by 1.
- ITER_W, 16, iteration counter width.
- MAX_ITER, 0, LOOP exits after this many iterations; 0 = unlimited.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- start  in  1  begin run; sampled in IDLE or DONE.
- bound_in  in  WIDTH  bound for the next run; latched when start is accepted.
- loop_en  in  1  continue looping; 0 ends the run.
- ch_en  in  NCH  per-channel step enable.
- inc  in  NCH  per-channel branch select: 1 = increment, 0 = wrap branch.
- c_out  out  NCH*WIDTH  counter values; channel i at bits [i*WIDTH +: WIDTH].
- bound_out  out  WIDTH  latched bound_q.
- state_out  out  2  IDLE = 0, LOOP = 1, DONE = 2.
- iter_out  out  ITER_W  completed loop iterations in the current run.
- done  out  1  high while in DONE.
- err  out  1  high if any c[i] > bound_q; must never be 1.

Behaviour:
- Reset (rst = 0, asynchronous, any state):
  - c[i] = 0, bound_q = DEFAULT_BOUND, state = IDLE, iter = 0, done = 0, err = 0.
  - Takes effect immediately and aborts any run in progress.
- IDLE:
  - start = 0: hold everything.
  - start = 1, next cycle: bound_q = max(bound_in, 1), all c[i] = 0, iter = 0, state = LOOP.
- LOOP, loop_en = 0: state = DONE next cycle; counters, iter and bound_q hold.
- LOOP, loop_en = 1, for each channel i independently, same cycle:
  - ch_en[i] = 0: hold.
  - ch_en[i] = 1, inc[i] = 1: if c[i] != bound_q then c[i] + 1, else hold (saturate at bound).
  - ch_en[i] = 1, inc[i] = 0, c[i] == bound_q, WRAP_MODE 0: c[i] = 1.
  - ch_en[i] = 1, inc[i] = 0, c[i] == bound_q, WRAP_MODE 1: c[i] = 0.
  - ch_en[i] = 1, inc[i] = 0, WRAP_MODE 2: if c[i] != 0 then c[i] - 1, regardless of c[i] == bound_q; at 0, hold.
  - ch_en[i] = 1, inc[i] = 0, c[i] != bound_q, WRAP_MODE 0 or 1: hold.
  - iter increments by 1 and saturates at all-ones.
  - If MAX_ITER != 0 and iter + 1 == MAX_ITER: state = DONE on this same edge; this step's counter updates still apply.
- DONE:
  - done = 1; all state holds.
  - start = 1: same action as from IDLE (restart with a fresh bound); done falls the next cycle.
- Output timing:
  - All outputs are registered values or direct decodes of registers.
  - Counter updates are visible on c_out one cycle after the sampling edge.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - Increment never exceeds bound_q, so no wrap-around past 2^WIDTH - 1, even with bound_q = all-ones.
- Invariants (to be asserted, disabled while rst = 0):
  - c[i] <= bound_q for all i.
  - bound_q >= 1.
  - err == 0.
  - state != 3.
  - In DONE, c[i] and bound_q are stable until start.
  - Each invariant must be 1-inductive together with: state == IDLE implies all c[i] == 0 after a restart.
- Simultaneous events:
  - start in LOOP is ignored.
  - The bound is sampled only on an accepted start; bound_in changes mid-run have no effect.

Test Plan:
- Reset release, then start = 1 with bound_in = 0 -> bound_out = 1, all c = 0, state = LOOP next cycle.
- bound_in = 4, loop_en = 1, ch_en = 4'b0001, inc = 1 for 6 cycles -> c0 sequence 1, 2, 3, 4, 4, 4; c1..c3 stay 0; iter = 6.
- WRAP_MODE 0, c0 = 4 = bound, inc0 = 0 -> c0 = 1; WRAP_MODE 1 same stimulus -> c0 = 0; WRAP_MODE 2 from c0 = 4 -> 3, and c0 = 0 holds at 0.
- MAX_ITER = 3, loop_en held at 1 -> DONE entered on the third LOOP edge, iter_out = 3, done = 1; then start with bound_in = 7 -> c cleared, bound_out = 7, state = LOOP.
- rst driven low mid-LOOP, between clock edges, with c0 = 3 -> c_out = 0, state = IDLE, bound_out = 4 immediately, without waiting for a clock edge.
- 2000-cycle random ch_en, inc, loop_en and bound_in stimulus in all three wrap modes, including bound_in = 2^WIDTH - 1 -> err stays 0 and every invariant holds.
